// File: rtl/spi_gen_pkg.sv
// Shared types for the SPI slave: FSM state encoding, the two-bit command
// codes carried in the word MSBs, and the command acceptance rule.
package spi_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        RX,
        WAIT_TX,
        TX,
        DONE
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Writes are always accepted; reads must alternate address then data.
    function automatic logic cmd_ok(input logic [1:0] cmd, input logic rd_seen);
        return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA) ||
               (cmd == (rd_seen ? CMD_RD_DATA : CMD_RD_ADDR));
    endfunction

endpackage

// File: rtl/spi_slave_gen_if.sv
// SPI slave bundle: serial pins plus the RAM-side command/read-data handshake.
//   slave  modport : the SPI slave (drives MISO, rx_*, frame_err, busy)
//   master modport : the pins/RAM side driving SS_n, MOSI, tx_*
interface spi_slave_gen_if #(parameter int DATA_W = 8);
    localparam int WORD_W = DATA_W + 2;

    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, frame_err, busy
    );

endinterface

// File: rtl/spi_tx_serializer.sv
// Parallel-to-serial shifter for RAM read data, MSB first.
//   clk, rst  : clock, async active-high reset
//   load_i    : capture data_i; its MSB is on miso_o the following cycle
//   clear_i   : drop any transfer in progress (miso_o goes low)
//   miso_o    : current bit while active, else 0
//   done_o    : high while the last bit is on miso_o
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              done_o
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] sh_q;
    logic [CW-1:0]     cnt_q;
    logic              act_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (load_i) begin
            sh_q  <= data_i;
            cnt_q <= CW'(DATA_W - 1);
            act_q <= 1'b1;
        end else if (act_q) begin
            if (cnt_q == '0) begin
                act_q <= 1'b0;
            end else begin
                sh_q  <= sh_q << 1;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign miso_o = act_q & sh_q[DATA_W-1];
    assign done_o = act_q && (cnt_q == '0);

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave: receives a {cmd[1:0], payload} word on MOSI for the RAM, checks
// the command order, and returns RAM read data on MISO.
//   clk, rst : clock, async active-high reset
//   bus      : spi_slave_gen_if slave modport (SS_n, MOSI, MISO, rx_data,
//              rx_valid, tx_data, tx_valid, frame_err, busy)
module spi_slave_gen
    import spi_gen_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    spi_slave_gen_if.slave  bus
);
    localparam int WORD_W = DATA_W + 2;
    localparam int BW     = $clog2(WORD_W);
    localparam int TW     = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [BW-1:0] BCNT_INIT = BW'(WORD_W - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TX_TIMEOUT - 1);

    state_t            state_q;
    logic [WORD_W-1:0] sh_q, rx_data_q;
    logic              rx_valid_q, frame_err_q, rd_seen_q;
    logic [BW-1:0]     bcnt_q;
    logic [TW-1:0]     wcnt_q;

    logic [WORD_W-1:0] sh_d;
    logic [1:0]        cmd_d;
    logic              ok_d;
    logic              ser_load, ser_miso, ser_done;

    assign sh_d  = {sh_q[WORD_W-2:0], bus.MOSI};
    assign cmd_d = sh_q[WORD_W-1 -: 2];
    assign ok_d  = cmd_ok(cmd_d, rd_seen_q);

    // SS_n high beats a same-edge tx_valid: nothing is loaded.
    assign ser_load = (state_q == WAIT_TX) && !bus.SS_n && bus.tx_valid;

    spi_tx_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load),
        .clear_i (bus.SS_n),
        .data_i  (bus.tx_data),
        .miso_o  (ser_miso),
        .done_o  (ser_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rd_seen_q   <= 1'b0;
            bcnt_q      <= '0;
            wcnt_q      <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                IDLE: if (!bus.SS_n) state_q <= CHK_CMD;
                CHK_CMD: begin
                    if (bus.SS_n) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        sh_q    <= sh_d;
                        bcnt_q  <= BCNT_INIT;
                        state_q <= RX;
                    end
                end
                RX: begin
                    if (bcnt_q == '0) begin
                        // Word fully held: it is delivered even if SS_n rose now.
                        if (ok_d) begin
                            rx_data_q  <= sh_q;
                            rx_valid_q <= 1'b1;
                            if (cmd_d == CMD_RD_ADDR) rd_seen_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        if (bus.SS_n) begin
                            state_q <= IDLE;
                        end else if (ok_d && cmd_d == CMD_RD_DATA) begin
                            wcnt_q  <= '0;
                            state_q <= WAIT_TX;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (bus.SS_n) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        sh_q   <= sh_d;
                        bcnt_q <= bcnt_q - BW'(1);
                    end
                end
                WAIT_TX: begin
                    if (bus.SS_n) begin
                        state_q <= IDLE;
                    end else if (bus.tx_valid) begin
                        state_q <= TX;
                    end else if (wcnt_q == TO_LAST) begin
                        frame_err_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        wcnt_q <= wcnt_q + TW'(1);
                    end
                end
                TX: begin
                    if (bus.SS_n) begin
                        state_q <= IDLE;
                    end else if (ser_done) begin
                        rd_seen_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: if (bus.SS_n) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.MISO      = ser_miso;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
